// File: rtl/conf_word_sequencer.sv
// Configuration word sequencer: reads a per-select header, then streams the sub-block's words onto the write bus.
// Optional trailing XOR checksum word enabled by defining CONF_CHKSUM_EN.
module conf_word_sequencer #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 8,
  parameter int CNT_W     = 6,
  parameter int HDR_BASE  = 0,
  parameter int MAX_WORDS = 32
) (
  input  logic              conf_clk,
  input  logic              reset,
  input  logic              conf_en,
  input  logic [2:0]        current_select,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              wr_en,
  output logic [CNT_W-1:0]  wr_idx,
  output logic [DATA_W-1:0] wr_data,
  output logic [7:0]        blk_sel,
  output logic              conf_ack,
  output logic              seq_error
);

  typedef enum logic [2:0] {IDLE, HDR, HLAT, STREAM, DRAIN, ACK, HOLD, ERR} state_t;

`ifdef CONF_CHKSUM_EN
  localparam logic [CNT_W:0] TRAIL_WORDS = (CNT_W+1)'(1);
`else
  localparam logic [CNT_W:0] TRAIL_WORDS = '0;
`endif

  state_t              r_state;
  logic [2:0]          r_sel;
  logic [2:0]          r_last_sel;
  logic [ADDR_W-1:0]   r_base;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W:0]      r_i;
  logic                r_mem_rd;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic                r_conf_ack;
  logic                r_seq_error;
  logic                r_rd_vld_p0;
  logic [CNT_W-1:0]    r_rd_idx_p0;
  logic                r_wr_en_p1;
  logic [CNT_W-1:0]    r_wr_idx_p1;
  logic [7:0]          r_blk_sel_p1;
`ifdef CONF_CHKSUM_EN
  logic [DATA_W-1:0]   r_xor;
`endif

  logic [ADDR_W-1:0]   w_hdr_base;
  logic [CNT_W-1:0]    w_hdr_cnt;
  logic [CNT_W:0]      w_nreads;
  logic                w_start;
  logic                w_wr_go;

  assign w_hdr_base = mem_rdata[ADDR_W-1:0];
  assign w_hdr_cnt  = mem_rdata[ADDR_W+CNT_W-1:ADDR_W];
  assign w_nreads   = {1'b0, r_cnt} + TRAIL_WORDS;
  assign w_start    = conf_en && (current_select != 3'd0) && (current_select != 3'd7) &&
                      (current_select != r_last_sel);
  // Dropping conf_en discards the word still in flight from memory.
  assign w_wr_go    = r_rd_vld_p0 && conf_en;

  always_ff @(posedge conf_clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_sel        <= '0;
      r_last_sel   <= '0;
      r_base       <= '0;
      r_cnt        <= '0;
      r_i          <= '0;
      r_mem_rd     <= 1'b0;
      r_mem_addr   <= '0;
      r_conf_ack   <= 1'b0;
      r_seq_error  <= 1'b0;
      r_rd_vld_p0  <= 1'b0;
      r_rd_idx_p0  <= '0;
      r_wr_en_p1   <= 1'b0;
      r_wr_idx_p1  <= '0;
      r_blk_sel_p1 <= '0;
`ifdef CONF_CHKSUM_EN
      r_xor        <= '0;
`endif
    end else begin
      // p0 -> p1: a read issued last cycle becomes a write this cycle
      r_wr_en_p1   <= w_wr_go;
      r_wr_idx_p1  <= w_wr_go ? r_rd_idx_p0 : '0;
      r_blk_sel_p1 <= w_wr_go ? (8'd1 << r_sel) : 8'd0;
`ifdef CONF_CHKSUM_EN
      if (r_wr_en_p1) r_xor <= r_xor ^ mem_rdata;
`endif
      r_mem_rd    <= 1'b0;
      r_rd_vld_p0 <= 1'b0;
      r_conf_ack  <= 1'b0;

      if (!conf_en && r_state != IDLE && r_state != ERR) begin
        r_state    <= IDLE;
        r_last_sel <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            if (!conf_en) begin
              r_last_sel <= '0;
            end else if (w_start) begin
              r_sel      <= current_select;
              r_mem_rd   <= 1'b1;
              r_mem_addr <= ADDR_W'(HDR_BASE) + ADDR_W'(current_select);
              r_state    <= HDR;
            end
          end
          HDR: r_state <= HLAT;
          HLAT: begin
            if (int'(w_hdr_cnt) > MAX_WORDS) begin
              r_seq_error <= 1'b1;
              r_state     <= ERR;
            end else if (w_hdr_cnt == '0) begin
              r_conf_ack <= 1'b1;
              r_last_sel <= r_sel;
              r_state    <= ACK;
            end else begin
              r_base      <= w_hdr_base;
              r_cnt       <= w_hdr_cnt;
              r_mem_rd    <= 1'b1;
              r_mem_addr  <= w_hdr_base;
              r_rd_vld_p0 <= 1'b1;
              r_rd_idx_p0 <= '0;
              r_i         <= (CNT_W+1)'(1);
`ifdef CONF_CHKSUM_EN
              r_xor       <= '0;
`endif
              r_state     <= STREAM;
            end
          end
          STREAM: begin
            if (r_i < w_nreads) begin
              r_mem_rd    <= 1'b1;
              r_mem_addr  <= r_base + ADDR_W'(r_i);
              // The trailing checksum read is never turned into a write.
              r_rd_vld_p0 <= (r_i < {1'b0, r_cnt});
              r_rd_idx_p0 <= r_i[CNT_W-1:0];
              r_i         <= r_i + (CNT_W+1)'(1);
            end else begin
              r_state <= DRAIN;
            end
          end
          DRAIN: begin
`ifdef CONF_CHKSUM_EN
            if (r_xor == mem_rdata) begin
              r_conf_ack <= 1'b1;
              r_last_sel <= r_sel;
              r_state    <= ACK;
            end else begin
              r_seq_error <= 1'b1;
              r_state     <= ERR;
            end
`else
            r_conf_ack <= 1'b1;
            r_last_sel <= r_sel;
            r_state    <= ACK;
`endif
          end
          ACK:  r_state <= HOLD;
          HOLD: r_state <= IDLE;
          ERR: begin
            if (!conf_en) begin
              r_state    <= IDLE;
              r_last_sel <= '0;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  // Write data is the memory's registered read port, gated so the bus idles at zero.
  assign mem_rd    = r_mem_rd;
  assign mem_addr  = r_mem_addr;
  assign wr_en     = r_wr_en_p1;
  assign wr_idx    = r_wr_idx_p1;
  assign wr_data   = r_wr_en_p1 ? mem_rdata : '0;
  assign blk_sel   = r_blk_sel_p1;
  assign conf_ack  = r_conf_ack;
  assign seq_error = r_seq_error;

endmodule

// File: tb/tb_conf_word_sequencer.sv
// Directed testbench for conf_word_sequencer with a one-cycle-latency memory model.
module tb_conf_word_sequencer;

`ifdef CONF_CHKSUM_EN
  localparam int CHK = 1;
`else
  localparam int CHK = 0;
`endif

  logic        conf_clk = 1'b0;
  logic        reset;
  logic        conf_en;
  logic [2:0]  current_select;
  logic        mem_rd;
  logic [7:0]  mem_addr;
  logic [31:0] mem_rdata = '0;
  logic        wr_en;
  logic [5:0]  wr_idx;
  logic [31:0] wr_data;
  logic [7:0]  blk_sel;
  logic        conf_ack;
  logic        seq_error;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  logic [31:0] mem [256];

  typedef struct {int cyc; int idx; logic [31:0] data; logic [7:0] blk;} wr_t;
  typedef struct {int cyc; logic [7:0] addr;} rd_t;
  wr_t wq[$];
  rd_t rq[$];
  int  aq[$];

  conf_word_sequencer dut (
    .conf_clk(conf_clk), .reset(reset), .conf_en(conf_en), .current_select(current_select),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data), .blk_sel(blk_sel),
    .conf_ack(conf_ack), .seq_error(seq_error)
  );

  always #5 conf_clk = ~conf_clk;
  always @(posedge conf_clk) cyc <= cyc + 1;
  always @(posedge conf_clk) if (mem_rd) mem_rdata <= mem[mem_addr];

  always @(negedge conf_clk) begin
    if (wr_en)    wq.push_back('{cyc: cyc, idx: int'(wr_idx), data: wr_data, blk: blk_sel});
    if (mem_rd)   rq.push_back('{cyc: cyc, addr: mem_addr});
    if (conf_ack) aq.push_back(cyc);
  end

  function automatic logic [31:0] hdr(input int cnt, input int base);
    return 32'((cnt << 8) | base);
  endfunction

  task automatic clear_log();
    wq.delete(); rq.delete(); aq.delete();
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge conf_clk);
  endtask

  task automatic start_sel(input logic [2:0] s, output int t);
    @(negedge conf_clk);
    conf_en = 1'b1;
    current_select = s;
    t = cyc;
  endtask

  task automatic test_reset();
    reset = 1'b1; conf_en = 1'b0; current_select = 3'd0;
    wait_cyc(2);
    n_total++; if (mem_rd !== 1'b0) $display("FAIL rst_mem_rd got %b want 0", mem_rd); else n_pass++;
    n_total++; if (mem_addr !== 8'h00) $display("FAIL rst_mem_addr got %h want 00", mem_addr); else n_pass++;
    n_total++; if (wr_en !== 1'b0) $display("FAIL rst_wr_en got %b want 0", wr_en); else n_pass++;
    n_total++; if (wr_idx !== 6'd0) $display("FAIL rst_wr_idx got %0d want 0", wr_idx); else n_pass++;
    n_total++; if (wr_data !== 32'h0) $display("FAIL rst_wr_data got %h want 0", wr_data); else n_pass++;
    n_total++; if (blk_sel !== 8'h00) $display("FAIL rst_blk_sel got %h want 00", blk_sel); else n_pass++;
    n_total++; if (conf_ack !== 1'b0) $display("FAIL rst_conf_ack got %b want 0", conf_ack); else n_pass++;
    n_total++; if (seq_error !== 1'b0) $display("FAIL rst_seq_error got %b want 0", seq_error); else n_pass++;
    @(negedge conf_clk) reset = 1'b0;
    wait_cyc(2);
  endtask

  task automatic test_basic();
    int t;
    logic [31:0] d [3];
    d[0] = 32'hA5A5_0001; d[1] = 32'h5A5A_0002; d[2] = 32'hDEAD_BEEF;
    mem[1] = hdr(3, 'h40);
    for (int k = 0; k < 3; k++) mem[8'h40 + k] = d[k];
    mem[8'h43] = d[0] ^ d[1] ^ d[2];
    @(negedge conf_clk) begin conf_en = 1'b1; current_select = 3'd0; end
    clear_log();
    wait_cyc(3);
    n_total++; if (rq.size() !== 0) $display("FAIL basic_sel0_idle got %0d reads want 0", rq.size()); else n_pass++;
    clear_log();
    start_sel(3'd1, t);
    wait_cyc(14);
    n_total++;
    if (rq.size() < 1 || rq[0].cyc !== t + 1 || rq[0].addr !== 8'h01)
      $display("FAIL basic_hdr_read got n=%0d cyc=%0d addr=%h want cyc=%0d addr=01",
               rq.size(), (rq.size() > 0) ? rq[0].cyc - t : -1, (rq.size() > 0) ? rq[0].addr : 8'hxx, 1);
    else n_pass++;
    n_total++; if (wq.size() !== 3) $display("FAIL basic_nwr got %0d want 3", wq.size()); else n_pass++;
    for (int k = 0; k < 3; k++) begin
      n_total++;
      if (wq.size() <= k || wq[k].cyc !== t + 4 + k || wq[k].idx !== k || wq[k].data !== d[k] || wq[k].blk !== 8'h02)
        $display("FAIL basic_wr%0d got cyc=T+%0d idx=%0d data=%h blk=%h want cyc=T+%0d idx=%0d data=%h blk=02",
                 k, (wq.size() > k) ? wq[k].cyc - t : -1, (wq.size() > k) ? wq[k].idx : -1,
                 (wq.size() > k) ? wq[k].data : 32'hx, (wq.size() > k) ? wq[k].blk : 8'hx, 4 + k, k, d[k]);
      else n_pass++;
    end
    n_total++;
    if (aq.size() !== 1 || aq[0] !== t + 7 + CHK)
      $display("FAIL basic_ack got n=%0d at T+%0d want n=1 at T+%0d", aq.size(), (aq.size() > 0) ? aq[0] - t : -1, 7 + CHK);
    else n_pass++;
  endtask

  task automatic test_zero_count();
    int t;
    mem[2] = hdr(0, 'h33);
    clear_log();
    start_sel(3'd2, t);
    wait_cyc(15);
    n_total++; if (wq.size() !== 0) $display("FAIL zero_nwr got %0d want 0", wq.size()); else n_pass++;
    n_total++;
    if (aq.size() !== 1 || aq[0] !== t + 3)
      $display("FAIL zero_ack got n=%0d at T+%0d want n=1 at T+3", aq.size(), (aq.size() > 0) ? aq[0] - t : -1);
    else n_pass++;
    n_total++; if (rq.size() !== 1) $display("FAIL zero_no_retrigger got %0d reads want 1", rq.size()); else n_pass++;
  endtask

  task automatic test_full_pass();
    logic [31:0] ed[$];
    int ei[$];
    logic [7:0] eb[$];
    int nack;
    for (int k = 1; k <= 6; k++) begin
      logic [31:0] x;
      int base;
      base = 'h80 + 16 * (k - 1);
      mem[k] = hdr(k, base);
      x = '0;
      for (int j = 0; j < k; j++) begin
        mem[base + j] = 32'hC0DE_0000 | 32'(k << 8) | 32'(j);
        x ^= mem[base + j];
        ed.push_back(mem[base + j]); ei.push_back(j); eb.push_back(8'(1 << k));
      end
      mem[base + k] = x;
    end
    @(negedge conf_clk) begin conf_en = 1'b0; current_select = 3'd0; end
    @(negedge conf_clk);
    clear_log();
    conf_en = 1'b1; current_select = 3'd1;
    nack = 0;
    for (int c = 0; c < 400 && nack < 6; c++) begin
      @(negedge conf_clk);
      if (conf_ack) begin
        nack++;
        current_select = (nack == 6) ? 3'd7 : 3'(nack + 1);
      end
    end
    n_total++; if (nack !== 6) $display("FAIL pass_loader_acks got %0d want 6 (timeout)", nack); else n_pass++;
    wait_cyc(20);
    n_total++; if (wq.size() !== 21) $display("FAIL pass_nwr got %0d want 21", wq.size()); else n_pass++;
    n_total++; if (aq.size() !== 6) $display("FAIL pass_nack got %0d want 6", aq.size()); else n_pass++;
    for (int n = 0; n < 21; n++) begin
      n_total++;
      if (wq.size() <= n || wq[n].idx !== ei[n] || wq[n].data !== ed[n] || wq[n].blk !== eb[n])
        $display("FAIL pass_wr%0d got idx=%0d data=%h blk=%h want idx=%0d data=%h blk=%h", n,
                 (wq.size() > n) ? wq[n].idx : -1, (wq.size() > n) ? wq[n].data : 32'hx,
                 (wq.size() > n) ? wq[n].blk : 8'hx, ei[n], ed[n], eb[n]);
      else n_pass++;
    end
    n_total++;
    if (aq.size() !== 6 || rq.size() == 0 || rq[rq.size() - 1].cyc >= aq[5])
      $display("FAIL pass_sel7_idle got last_read=%0d last_ack=%0d want read before ack",
               (rq.size() > 0) ? rq[rq.size() - 1].cyc : -1, (aq.size() == 6) ? aq[5] : -1);
    else n_pass++;
  endtask

  task automatic test_error();
    int t;
    mem[3] = hdr(33, 'h10);
    clear_log();
    start_sel(3'd3, t);
    wait_cyc(10);
    n_total++; if (seq_error !== 1'b1) $display("FAIL err_flag got %b want 1", seq_error); else n_pass++;
    n_total++; if (wq.size() !== 0 || aq.size() !== 0) $display("FAIL err_quiet got wr=%0d ack=%0d want 0/0", wq.size(), aq.size()); else n_pass++;
    n_total++; if (rq.size() !== 1) $display("FAIL err_reads got %0d want 1", rq.size()); else n_pass++;
    @(negedge conf_clk) conf_en = 1'b0;
    wait_cyc(3);
    n_total++; if (seq_error !== 1'b1) $display("FAIL err_sticky got %b want 1", seq_error); else n_pass++;
    mem[1] = hdr(3, 'h40);
    clear_log();
    start_sel(3'd1, t);
    wait_cyc(12);
    n_total++;
    if (wq.size() !== 3 || aq.size() !== 1 || aq[0] !== t + 7 + CHK)
      $display("FAIL err_recover got wr=%0d ack=%0d at T+%0d want wr=3 ack=1 at T+%0d",
               wq.size(), aq.size(), (aq.size() > 0) ? aq[0] - t : -1, 7 + CHK);
    else n_pass++;
    n_total++; if (seq_error !== 1'b1) $display("FAIL err_sticky2 got %b want 1", seq_error); else n_pass++;
  endtask

  task automatic test_abort_reset();
    int t;
    logic [31:0] x;
    mem[4] = hdr(5, 'h60);
    x = '0;
    for (int j = 0; j < 5; j++) begin mem[8'h60 + j] = 32'h0BAD_0000 + 32'(j); x ^= mem[8'h60 + j]; end
    mem[8'h65] = x;
    clear_log();
    start_sel(3'd4, t);
    wait_cyc(5);
    conf_en = 1'b0;
    wait_cyc(10);
    n_total++;
    if (wq.size() !== 2 || wq[1].idx !== 1)
      $display("FAIL abort_nwr got %0d writes want 2 (idx 0,1)", wq.size());
    else n_pass++;
    n_total++; if (aq.size() !== 0) $display("FAIL abort_noack got %0d want 0", aq.size()); else n_pass++;
    n_total++; if (mem_rd !== 1'b0 || wr_en !== 1'b0) $display("FAIL abort_idle got rd=%b wr=%b want 0/0", mem_rd, wr_en); else n_pass++;
    clear_log();
    start_sel(3'd4, t);
    wait_cyc(5);
    n_total++;
    if (wr_en !== 1'b1 || wr_idx !== 6'd1 || wr_data !== 32'h0BAD_0001)
      $display("FAIL rst_mid_pre got wr=%b idx=%0d data=%h want 1/1/0bad0001", wr_en, wr_idx, wr_data);
    else n_pass++;
    reset = 1'b1;
    #1;
    n_total++;
    if ({mem_rd, mem_addr, wr_en, wr_idx, wr_data, blk_sel, conf_ack, seq_error} !== '0)
      $display("FAIL rst_mid_async got rd=%b addr=%h wr=%b idx=%0d data=%h blk=%h ack=%b err=%b want all 0",
               mem_rd, mem_addr, wr_en, wr_idx, wr_data, blk_sel, conf_ack, seq_error);
    else n_pass++;
    conf_en = 1'b0; current_select = 3'd0;
    @(negedge conf_clk) reset = 1'b0;
    wait_cyc(2);
    n_total++; if (seq_error !== 1'b0 || mem_rd !== 1'b0) $display("FAIL rst_mid_after got err=%b rd=%b want 0/0", seq_error, mem_rd); else n_pass++;
  endtask

  task automatic test_wrap();
    int t;
    logic [31:0] d [3];
    logic [7:0] a [3];
    d[0] = 32'h1111_2222; d[1] = 32'h3333_4444; d[2] = 32'h5555_6666;
    a[0] = 8'hFE; a[1] = 8'hFF; a[2] = 8'h00;
    mem[5] = hdr(3, 'hFE);
    for (int k = 0; k < 3; k++) mem[a[k]] = d[k];
    mem[1] = d[0] ^ d[1] ^ d[2];
    clear_log();
    start_sel(3'd5, t);
    wait_cyc(14);
    n_total++; if (rq.size() !== 4 + CHK) $display("FAIL wrap_nreads got %0d want %0d", rq.size(), 4 + CHK); else n_pass++;
    for (int k = 0; k < 3; k++) begin
      n_total++;
      if (rq.size() <= k + 1 || rq[k + 1].addr !== a[k] || rq[k + 1].cyc !== t + 3 + k)
        $display("FAIL wrap_rd%0d got addr=%h want %h", k, (rq.size() > k + 1) ? rq[k + 1].addr : 8'hxx, a[k]);
      else n_pass++;
      n_total++;
      if (wq.size() <= k || wq[k].data !== d[k] || wq[k].idx !== k || wq[k].blk !== 8'h20)
        $display("FAIL wrap_wr%0d got data=%h want %h", k, (wq.size() > k) ? wq[k].data : 32'hx, d[k]);
      else n_pass++;
    end
    n_total++;
    if (aq.size() !== 1 || aq[0] !== t + 7 + CHK)
      $display("FAIL wrap_ack got n=%0d at T+%0d want n=1 at T+%0d", aq.size(), (aq.size() > 0) ? aq[0] - t : -1, 7 + CHK);
    else n_pass++;
`ifdef CONF_CHKSUM_EN
    n_total++;
    if (rq.size() < 5 || rq[4].addr !== 8'h01)
      $display("FAIL wrap_chk_read got addr=%h want 01", (rq.size() > 4) ? rq[4].addr : 8'hxx);
    else n_pass++;
    @(negedge conf_clk) conf_en = 1'b0;
    mem[1] = d[0] ^ d[1] ^ d[2] ^ 32'h1;
    clear_log();
    start_sel(3'd5, t);
    wait_cyc(14);
    n_total++;
    if (seq_error !== 1'b1 || aq.size() !== 0 || wq.size() !== 3)
      $display("FAIL wrap_chk_bad got err=%b ack=%0d wr=%0d want 1/0/3", seq_error, aq.size(), wq.size());
    else n_pass++;
`endif
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    test_reset();
    test_basic();
    test_zero_count();
    test_full_pass();
    test_error();
    test_abort_reset();
    test_wrap();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
